// File: rtl/input_handling_bank_pkg.sv
// Shared constants for the button input bank: mode encodings, default timing and a counter-width helper.
package input_handling_bank_pkg;

  localparam logic MODE_MOMENTARY = 1'b0;
  localparam logic MODE_TOGGLE    = 1'b1;

  localparam int DB_CYCLES_DEFAULT   = 50000;
  localparam int HOLD_CYCLES_DEFAULT = 50000000;

  // $clog2 of the count limit, never narrower than one bit
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/input_handling_bank_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, rising-edge strobe, toggle/follow state
// and, when INPUT_HOLD_EN is defined, a long-press hold flag.
module input_channel
  import input_handling_bank_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic mode,
  input  logic force_en,
  output logic level,
  output logic pulse,
  output logic state,
  output logic hold
);

  localparam int DBW = cnt_width(DB_CYCLES);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d, level_prev_q, level_prev_d;
  logic           pulse_q, pulse_d, state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      db_cnt_q     <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      pulse_q      <= 1'b0;
      state_q      <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      db_cnt_q     <= db_cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_prev_d;
      pulse_q      <= pulse_d;
      state_q      <= state_d;
    end
  end

  always_comb begin
    sync1_d      = btn;
    sync2_d      = sync1_q;
    db_cnt_d     = db_cnt_q;
    level_d      = level_q;
    // Any sample matching the current level restarts the stability count
    if (sync2_q == level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      level_d  = ~level_q;
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    level_prev_d = level_q;
    pulse_d      = level_q & ~level_prev_q;
    if (mode == MODE_TOGGLE) begin
      state_d = pulse_q ? (force_en ? 1'b1 : ~state_q) : state_q;
    end else begin
      state_d = level_q;
    end
  end

  assign level = level_q;
  assign pulse = pulse_q;
  assign state = state_q;

`ifdef INPUT_HOLD_EN
  localparam int HW = cnt_width(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          hold_q, hold_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= '0;
      hold_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      hold_q     <= hold_d;
    end
  end

  // The hold flag itself marks saturation, so the counter freezes instead of wrapping
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    hold_d     = hold_q;
    if (!level_q) begin
      hold_cnt_d = '0;
      hold_d     = 1'b0;
    end else if (!hold_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        hold_d = 1'b1;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  assign hold = hold_q;
`else
  // Hold feature absent: flag tied low, the parameter only keeps the interface uniform
  assign hold = (HOLD_CYCLES < 0);
`endif

endmodule

// File: rtl/input_handling_bank.sv
// Bank of N_BTN independent debounced button channels; optional long-press flag via INPUT_HOLD_EN.
// force_en carries the per-channel "press latches 1" control.
module input_handling_bank
  import input_handling_bank_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int DB_CYCLES   = DB_CYCLES_DEFAULT,
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn,
  input  logic [N_BTN-1:0] mode,
  input  logic [N_BTN-1:0] force_en,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_pulse,
  output logic [N_BTN-1:0] o_state,
  output logic [N_BTN-1:0] o_hold
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    input_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .btn     (btn[i]),
      .mode    (mode[i]),
      .force_en(force_en[i]),
      .level   (o_level[i]),
      .pulse   (o_pulse[i]),
      .state   (o_state[i]),
      .hold    (o_hold[i])
    );
  end

endmodule

// File: tb/tb_input_handling_bank.sv
// Self-checking bench for input_handling_bank (N_BTN=4, DB_CYCLES=4, HOLD_CYCLES=8).
module tb_input_handling_bank;

  localparam int N = 4;
  localparam int DB = 4;
  localparam int HOLD = 8;
  localparam int HMAX = 16384;
`ifdef INPUT_HOLD_EN
  localparam bit HOLD_ON = 1'b1;
`else
  localparam bit HOLD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] btn = '0, mode = '1, force_en = '0;
  logic [N-1:0] o_level, o_pulse, o_state, o_hold;

  int n_cmp = 0;
  int n_err = 0;
  int pulse_cnt;

  input_handling_bank #(.N_BTN(N), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .btn(btn), .mode(mode), .force_en(force_en),
    .o_level(o_level), .o_pulse(o_pulse), .o_state(o_state), .o_hold(o_hold)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: history of sampled inputs and expected outputs, indexed by edges since reset.
  logic [N-1:0] b_h [HMAX];
  logic [N-1:0] l_h [HMAX];
  logic [N-1:0] p_h [HMAX];
  logic [N-1:0] s_h [HMAX];
  int e = 0;
  logic [N-1:0] exp_l = '0, exp_p = '0, exp_s = '0, exp_h = '0;

  function automatic logic [N-1:0] get_b(int j); return (j < 1) ? '0 : b_h[j]; endfunction
  function automatic logic [N-1:0] get_l(int j); return (j < 1) ? '0 : l_h[j]; endfunction
  function automatic logic [N-1:0] get_p(int j); return (j < 1) ? '0 : p_h[j]; endfunction
  function automatic logic [N-1:0] get_s(int j); return (j < 1) ? '0 : s_h[j]; endfunction

  always @(posedge clk) begin
    logic [N-1:0] lp, lpp, pp, sp, bv, lv;
    logic flip, hh;
    if (rst) begin
      e = 0;
      exp_l = '0; exp_p = '0; exp_s = '0; exp_h = '0;
    end else begin
      if (e < HMAX - 1) e = e + 1;
      b_h[e] = btn;
      lp = get_l(e - 1); lpp = get_l(e - 2); pp = get_p(e - 1); sp = get_s(e - 1);
      exp_h = '0;
      for (int ch = 0; ch < N; ch++) begin
        // new level accepted once the synchronized input (btn two edges back) disagreed for DB edges running
        flip = 1'b1;
        for (int k = 0; k < DB; k++) begin
          bv = get_b(e - 2 - k);
          if (bv[ch] == lp[ch]) flip = 1'b0;
        end
        l_h[e][ch] = lp[ch] ^ flip;
        p_h[e][ch] = lp[ch] & ~lpp[ch];
        if (mode[ch]) s_h[e][ch] = pp[ch] ? (force_en[ch] ? 1'b1 : ~sp[ch]) : sp[ch];
        else          s_h[e][ch] = lp[ch];
        hh = 1'b1;
        for (int k = 0; k < HOLD; k++) begin
          lv = get_l(e - 1 - k);
          if (!lv[ch]) hh = 1'b0;
        end
        exp_h[ch] = HOLD_ON & hh;
      end
      exp_l = l_h[e]; exp_p = p_h[e]; exp_s = s_h[e];
    end
    #1;
    chk("model_level", o_level, exp_l);
    chk("model_pulse", o_pulse, exp_p);
    chk("model_state", o_state, exp_s);
    chk("model_hold",  o_hold,  exp_h);
  end

  task automatic idle(input int n, input int ch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (o_pulse[ch]) pulse_cnt++;
    end
  endtask

  typedef struct {
    int   ch;
    logic md;
    logic fc;
    logic press;
    logic exp_state;
    int   exp_pulses;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{2, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vecs[1] = '{2, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vecs[2] = '{2, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vecs[3] = '{2, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{2, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[5] = '{2, 1'b1, 1'b0, 1'b1, 1'b1, 1};
    vecs[6] = '{0, 1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[7] = '{1, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    vecs[8] = '{3, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[9] = '{3, 1'b0, 1'b1, 1'b1, 1'b0, 1};

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("reset_level", o_level, 4'h0);
    chk("reset_pulse", o_pulse, 4'h0);
    chk("reset_state", o_state, 4'h0);
    chk("reset_hold",  o_hold,  4'h0);

    // Clean press on channel 0, released together with reset
    rst = 1'b0; btn = 4'b0001;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("clean_level0", o_level[0], c >= 6);
      chk("clean_pulse0", o_pulse[0], c == 7);
      chk("clean_state0", o_state[0], c >= 8);
    end
    btn[0] = 1'b0;
    idle(12, 0);

    // Bouncing press on channel 1
    btn[1] = 1'b1; @(negedge clk);
    btn[1] = 1'b0; @(negedge clk);
    btn[1] = 1'b1; @(negedge clk);
    btn[1] = 1'b0; @(negedge clk);
    btn[1] = 1'b1;
    pulse_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (o_pulse[1]) pulse_cnt++;
      chk("bounce_pulse1", o_pulse[1], c == 7);
    end
    chk("bounce_pulses1", pulse_cnt, 1);
    chk("bounce_state1", o_state[1], 1'b1);
    btn[1] = 1'b0;
    idle(12, 1);

    // Table of press / no-press vectors
    for (int v = 0; v < 10; v++) begin
      mode[vecs[v].ch] = vecs[v].md;
      force_en[vecs[v].ch] = vecs[v].fc;
      pulse_cnt = 0;
      if (vecs[v].press) btn[vecs[v].ch] = 1'b1;
      idle(10, vecs[v].ch);
      btn[vecs[v].ch] = 1'b0;
      idle(12, vecs[v].ch);
      chk($sformatf("vec%0d_state", v), o_state[vecs[v].ch], vecs[v].exp_state);
      chk($sformatf("vec%0d_pulses", v), pulse_cnt, vecs[v].exp_pulses);
    end
    force_en = '0;

    // Momentary channel 3: 10-cycle press, state one cycle behind level, hold flag
    btn[3] = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      chk("mom_level3", o_level[3], (c >= 6) && (c <= 15));
      chk("mom_state3", o_state[3], (c >= 7) && (c <= 16));
      chk("mom_hold3",  o_hold[3],  HOLD_ON && (c >= 14) && (c <= 16));
      if (c == 10) btn[3] = 1'b0;
    end

    // Reset mid-debounce with channel 0 held
    mode = 4'b1111;
    btn[0] = 1'b1;
    idle(3, 0);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", {o_level, o_pulse, o_state, o_hold}, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("midrst_pulse0", o_pulse[0], c == 7);
      chk("midrst_level0", o_level[0], c >= 6);
    end
    btn[0] = 1'b0;
    idle(12, 0);

    // All four channels in the same cycle
    rst = 1'b1; @(negedge clk);
    rst = 1'b0; btn = 4'b1111;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      chk("all_pulse", o_pulse, (c == 7) ? 4'hF : 4'h0);
      if (c >= 8) chk("all_state", o_state, 4'hF);
    end
    btn = '0;
    idle(12, 0);

    // Random stimulus against the model
    for (int i = 0; i < 700; i++) begin
      btn = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) mode = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) force_en = 4'($urandom_range(0, 15));
      idle($urandom_range(1, 9), 0);
    end
    btn = '0;
    idle(20, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
